// File: rtl/axi4s_pkt_fifo.sv
// AXI4-Stream FIFO with full sideband, first-word-fall-through output register
// and an optional store-and-forward packet mode.
// Storage is a circular RAM. The output register is loaded from the RAM head
// with a registered read. occupancy counts every beat held, including the one
// currently presented on m_*.
module axi4s_pkt_fifo #(
  parameter int TDATA_WIDTH = 8,
  parameter int TKEEP_WIDTH = TDATA_WIDTH/8,
  parameter int TSTRB_WIDTH = TDATA_WIDTH/8,
  parameter int TUSER_WIDTH = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0,
  localparam int CW         = $clog2(DEPTH)+1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [TDATA_WIDTH-1:0] s_tdata,
  input  logic [TKEEP_WIDTH-1:0] s_tkeep,
  input  logic [TSTRB_WIDTH-1:0] s_tstrb,
  input  logic [TUSER_WIDTH-1:0] s_tuser,
  input  logic [TDEST_WIDTH-1:0] s_tdest,
  input  logic [TID_WIDTH-1:0]   s_tid,
  input  logic                   s_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [TDATA_WIDTH-1:0] m_tdata,
  output logic [TKEEP_WIDTH-1:0] m_tkeep,
  output logic [TSTRB_WIDTH-1:0] m_tstrb,
  output logic [TUSER_WIDTH-1:0] m_tuser,
  output logic [TDEST_WIDTH-1:0] m_tdest,
  output logic [TID_WIDTH-1:0]   m_tid,
  output logic                   m_tlast,
  output logic [CW-1:0]          occupancy,
  output logic [CW-1:0]          pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = TDATA_WIDTH + TKEEP_WIDTH + TSTRB_WIDTH + TUSER_WIDTH
                      + TDEST_WIDTH + TID_WIDTH + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PKT   = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  state_t state_reg;

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  s_word;
  logic [W-1:0]  out_word_reg;
  logic [CW-1:0] wr_ptr_reg;
  logic [CW-1:0] rd_ptr_reg;
  logic [CW-1:0] occupancy_next;
  logic [CW-1:0] pkt_count_next;
  logic [CW-1:0] ram_pkts;
  logic          wr_en;
  logic          rd_en;
  logic          ram_avail;
  logic          next_first;
  logic          gate_open;
  logic          load;

  assign s_word = {s_tlast, s_tid, s_tdest, s_tuser, s_tstrb, s_tkeep, s_tdata};
  assign {m_tlast, m_tid, m_tdest, m_tuser, m_tstrb, m_tkeep, m_tdata} = out_word_reg;

  assign wr_en = s_tvalid & s_tready;
  assign rd_en = m_tvalid & m_tready;

  // Pointers carry one extra bit so a completely full RAM differs from empty.
  assign ram_avail = (wr_ptr_reg != rd_ptr_reg);

  // The RAM head starts a new packet when the presented beat ends one, or,
  // with nothing presented, when no packet is in flight.
  assign next_first = m_tvalid ? m_tlast : (state_reg == ST_IDLE);

  // Complete packets still in the RAM, excluding a tlast beat already presented.
  assign ram_pkts = pkt_count - {{(CW-1){1'b0}}, m_tvalid & m_tlast};

  // Packet mode holds back the first beat of a packet until its tlast is stored.
  // FORCE makes next_first false, so an oversize packet drains as cut-through.
  assign gate_open = (PACKET_MODE == 0) || !next_first || (ram_pkts != '0);

  // Load the output register whenever it is free or being emptied this cycle.
  assign load = ram_avail && (!m_tvalid || m_tready) && gate_open;

  // Next values of both counters, covering simultaneous increment and decrement.
  always_comb begin
    occupancy_next = occupancy;
    pkt_count_next = pkt_count;
    if (wr_en && !rd_en) begin
      occupancy_next = occupancy + ONE;
    end else if (!wr_en && rd_en) begin
      occupancy_next = occupancy - ONE;
    end
    if ((wr_en && s_tlast) && !(rd_en && m_tlast)) begin
      pkt_count_next = pkt_count + ONE;
    end else if (!(wr_en && s_tlast) && (rd_en && m_tlast)) begin
      pkt_count_next = pkt_count - ONE;
    end
  end

  // Payload storage: no reset, so it can map onto block RAM.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= s_word;
    end
  end

  // Write and read pointers, wrapping modulo DEPTH through the low AW bits.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + ONE;
      end
      if (load) begin
        rd_ptr_reg <= rd_ptr_reg + ONE;
      end
    end
  end

  // First-word-fall-through output register (registered RAM read).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_word_reg <= '0;
      m_tvalid     <= 1'b0;
    end else if (load) begin
      out_word_reg <= mem[rd_ptr_reg[AW-1:0]];
      m_tvalid     <= 1'b1;
    end else if (rd_en) begin
      m_tvalid     <= 1'b0;
    end
  end

  // Occupancy, packet count and registered s_tready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      occupancy <= '0;
      pkt_count <= '0;
      s_tready  <= 1'b0;
    end else begin
      occupancy <= occupancy_next;
      pkt_count <= pkt_count_next;
      s_tready  <= (occupancy_next < FULL_LVL);
    end
  end

  // Packet-mode state: IDLE waits for a first beat, PKT forwards the rest of
  // a packet, and FORCE drains a packet larger than the FIFO.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (rd_en && !m_tlast) begin
            state_reg <= ST_PKT;
          end else if ((PACKET_MODE != 0) && (occupancy == FULL_LVL) && (pkt_count == '0)) begin
            state_reg <= ST_FORCE;
          end
        end
        ST_PKT, ST_FORCE: begin
          if (rd_en && m_tlast) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
